// File: rtl/truth_table_scanner_if.sv
// Host / function-unit bundle for the truth-table scanner.
// The slave side is the scanner: it takes host requests and function-unit outputs,
// and returns stimulus, captured table, minterm count and status.
interface truth_table_scanner_if;
    logic        start;
    logic [2:0]  sel;
    logic        mode3;
    logic [4:0]  s;
    logic        x;
    logic        y;
    logic        w;
    logic        z;
    logic [15:0] table_o;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, sel, mode3, s,
        input  x, y, w, z, table_o, count, busy, done, err
    );

    modport slave (
        input  start, sel, mode3, s,
        output x, y, w, z, table_o, count, busy, done, err
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Scan engine: walks a 4-input function unit through all input rows (16, or 8 in
// 3-variable mode), records one selected output per row into a truth table and
// counts the minterms. Each row is held for an APPLY (settle) and a SAMPLE cycle.
module truth_table_scanner (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_idx;
    logic [2:0]  r_sel_q;
    logic        r_mode3_q;
    logic [15:0] r_table;
    logic [4:0]  r_count;
    logic        r_err;

    logic        w_accept;
    logic        w_reject;
    logic        w_last;
    logic        w_bit;
    logic [3:0]  w_stim;

    assign w_accept = (r_state == IDLE) && bus.start && (bus.sel <= 3'd4);
    assign w_reject = (r_state == IDLE) && bus.start && (bus.sel > 3'd4);
    assign w_last   = r_mode3_q ? (r_idx == 4'd7) : (r_idx == 4'd15);
    assign w_bit    = bus.s[r_sel_q];

    // 3-variable mode maps idx[2:0] onto {x,y,z} and parks w at 0
    assign w_stim   = r_mode3_q ? {r_idx[2], r_idx[1], 1'b0, r_idx[0]} : r_idx;

    assign bus.x       = w_stim[3];
    assign bus.y       = w_stim[2];
    assign bus.w       = w_stim[1];
    assign bus.z       = w_stim[0];
    assign bus.table_o = r_table;
    assign bus.count   = r_count;
    assign bus.busy    = (r_state == APPLY) || (r_state == SAMPLE);
    assign bus.done    = (r_state == DONE);
    assign bus.err     = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one settle and one sample cycle per row
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = APPLY;
            APPLY:   w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? DONE : APPLY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Scan datapath: request latching, row index, table capture and minterm count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_sel_q   <= '0;
            r_mode3_q <= 1'b0;
            r_table   <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_sel_q   <= bus.sel;
                r_mode3_q <= bus.mode3;
                r_idx     <= '0;
                r_table   <= '0;
                r_count   <= '0;
            end else if (r_state == SAMPLE) begin
                r_table[r_idx] <= w_bit;
                r_count        <= r_count + {4'd0, w_bit};
                if (!w_last) begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner. A behavioural function unit answers the
// stimulus with five fixed truth tables; each scan is checked for table, count,
// row sequencing, latency and status pulses.
module tb_truth_table_scanner;

    logic clk;
    logic reset;

    truth_table_scanner_if bus ();

    truth_table_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function unit: s1/s2 depend on {x,y,z} only, s3..s5 on {x,y,w,z}
    localparam logic [7:0]  F1 = 8'hE4;
    localparam logic [7:0]  F2 = 8'hCA;
    localparam logic [15:0] F3 = 16'h90D6;
    localparam logic [15:0] F4 = 16'h3526;
    localparam logic [15:0] F5 = 16'h22A5;

    logic [3:0] fu_v4;
    logic [2:0] fu_v3;

    always_comb begin
        fu_v4 = {bus.x, bus.y, bus.w, bus.z};
        fu_v3 = {bus.x, bus.y, bus.z};
        bus.s = {F5[fu_v4], F4[fu_v4], F3[fu_v4], F2[fu_v3], F1[fu_v3]};
    end

    int unsigned n_checks;
    int unsigned n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a scan from IDLE and follow it to completion (bounded wait on done)
    task automatic scan(input logic [2:0] sl, input logic m3, input logic [15:0] exp_tab,
                        input logic [4:0] exp_cnt, input logic poke);
        int unsigned lat;
        int unsigned row;
        int unsigned last_lat;
        logic [3:0]  exp_stim;
        last_lat  = m3 ? 17 : 33;
        bus.start = 1'b1;
        bus.sel   = sl;
        bus.mode3 = m3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sel   = 3'd7;
        bus.mode3 = ~m3;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            row      = (lat - 1) / 2;
            exp_stim = m3 ? {row[2], row[1], 1'b0, row[0]} : row[3:0];
            chk("stim", {28'd0, bus.x, bus.y, bus.w, bus.z}, {28'd0, exp_stim});
            chk("busy_in_scan", {31'd0, bus.busy}, 32'd1);
            chk("err_in_scan", {31'd0, bus.err}, 32'd0);
            bus.start = poke && (lat == 5);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("done_latency", lat, last_lat);
        chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
        chk("table", {16'd0, bus.table_o}, {16'd0, exp_tab});
        chk("count", {27'd0, bus.count}, {27'd0, exp_cnt});
        @(negedge clk);
        chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        chk("table_hold", {16'd0, bus.table_o}, {16'd0, exp_tab});
        chk("count_hold", {27'd0, bus.count}, {27'd0, exp_cnt});
        bus.sel   = 3'd0;
        bus.mode3 = 1'b0;
    endtask

    initial begin
        int unsigned lat;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sel   = 3'd0;
        bus.mode3 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_table", {16'd0, bus.table_o}, 32'd0);
        chk("rst_count", {27'd0, bus.count}, 32'd0);
        chk("rst_stim", {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full scans for every legal select
        scan(3'd0, 1'b1, 16'h00E4, 5'd4, 1'b0);
        scan(3'd1, 1'b1, 16'h00CA, 5'd4, 1'b0);
        scan(3'd2, 1'b0, 16'h90D6, 5'd7, 1'b0);
        scan(3'd3, 1'b0, 16'h3526, 5'd7, 1'b0);
        scan(3'd4, 1'b0, 16'h22A5, 5'd6, 1'b1);

        // Illegal select: one-cycle err, nothing else moves
        bus.start = 1'b1;
        bus.sel   = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sel   = 3'd0;
        chk("err_pulse", {31'd0, bus.err}, 32'd1);
        chk("err_busy", {31'd0, bus.busy}, 32'd0);
        chk("err_table_keep", {16'd0, bus.table_o}, 32'h22A5);
        chk("err_count_keep", {27'd0, bus.count}, 32'd6);
        @(negedge clk);
        chk("err_width", {31'd0, bus.err}, 32'd0);
        chk("err_no_scan", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of a 4-variable scan
        bus.start = 1'b1;
        bus.sel   = 3'd4;
        bus.mode3 = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("partial_table", {16'd0, bus.table_o}, 32'h0005);
        chk("partial_count", {27'd0, bus.count}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_table", {16'd0, bus.table_o}, 32'd0);
        chk("midrst_count", {27'd0, bus.count}, 32'd0);
        chk("midrst_stim", {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {30'd0, bus.done, bus.busy}, 32'd0);
        end
        scan(3'd4, 1'b0, 16'h22A5, 5'd6, 1'b0);

        // Start and reset on the same edge: reset wins
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.sel   = 3'd2;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_vs_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_vs_start_table", {16'd0, bus.table_o}, 32'd0);
        @(negedge clk);
        chk("rst_vs_start_idle", {31'd0, bus.busy}, 32'd0);

        // Back-to-back scans with start held high
        bus.start = 1'b1;
        bus.sel   = 3'd1;
        bus.mode3 = 1'b1;
        @(negedge clk);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency1", lat, 32'd17);
        chk("b2b_table1", {16'd0, bus.table_o}, 32'h00CA);
        @(negedge clk);
        chk("b2b_idle_gap", {30'd0, bus.done, bus.busy}, 32'd0);
        @(negedge clk);
        chk("b2b_restart", {31'd0, bus.busy}, 32'd1);
        chk("b2b_cleared", {16'd0, bus.table_o}, 32'd0);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("b2b_latency2", lat, 32'd17);
        chk("b2b_table2", {16'd0, bus.table_o}, 32'h00CA);
        chk("b2b_count2", {27'd0, bus.count}, 32'd4);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
